sobel_row_scheduler: RTL and testbench

SOBEL_ROW_SCHEDULER -- requirements
Module: sobel_row_scheduler

---
 rtl/sobel_row_scheduler.sv | 148 ++++++++++++++
 tb/tb_sobel_row_scheduler.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sobel_row_scheduler.sv
// Row scheduler for a 3x3 Sobel filter. It fetches frame rows into a
// three-slot rotating line buffer and presents, for each output row, the
// three slots holding rows r-1, r and r+1. The top and bottom edge rows are
// replicated.
module sobel_row_scheduler #(
  parameter int unsigned ROW = 256,
  parameter int unsigned AW  = 8
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          start,
  output logic          rd_req,
  output logic [AW-1:0] rd_addr,
  input  logic          rd_ack,
  output logic          load_en,
  output logic [1:0]    load_sel,
  output logic [1:0]    win_top,
  output logic [1:0]    win_mid,
  output logic [1:0]    win_bot,
  output logic          win_valid,
  input  logic          out_ready,
  output logic [AW-1:0] out_row,
  output logic          busy,
  output logic          done
);

  typedef enum logic [1:0] {
    StIdle,
    StFetch,
    StCompute,
    StDone
  } state_e;

  localparam logic [AW-1:0] LastRow   = AW'(ROW - 1);
  localparam logic [AW-1:0] PenultRow = AW'(ROW - 2);
  localparam logic [AW-1:0] RowOne    = AW'(1);

  state_e        state_q, state_d;
  // Next row to fetch, and the slot it lands in (row mod 3, kept by rotation).
  logic [AW-1:0] fetch_row_q, fetch_row_d;
  logic [1:0]    fetch_slot_q, fetch_slot_d;
  // Row being filtered, and the slot that holds it.
  logic [AW-1:0] out_row_q, out_row_d;
  logic [1:0]    mid_slot_q, mid_slot_d;

  // Mod-3 slot rotation, forwards and backwards.
  function automatic logic [1:0] slot_inc(input logic [1:0] s);
    return (s == 2'd2) ? 2'd0 : s + 2'd1;
  endfunction

  function automatic logic [1:0] slot_dec(input logic [1:0] s);
    return (s == 2'd0) ? 2'd2 : s - 2'd1;
  endfunction

  // State and pointer registers, synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q      <= StIdle;
      fetch_row_q  <= '0;
      fetch_slot_q <= 2'd0;
      out_row_q    <= '0;
      mid_slot_q   <= 2'd0;
    end else begin
      state_q      <= state_d;
      fetch_row_q  <= fetch_row_d;
      fetch_slot_q <= fetch_slot_d;
      out_row_q    <= out_row_d;
      mid_slot_q   <= mid_slot_d;
    end
  end

  // Next-state logic: priming fetches, one fetch per transfer, edge rows.
  always_comb begin
    state_d      = state_q;
    fetch_row_d  = fetch_row_q;
    fetch_slot_d = fetch_slot_q;
    out_row_d    = out_row_q;
    mid_slot_d   = mid_slot_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d      = StFetch;
          fetch_row_d  = '0;
          fetch_slot_d = 2'd0;
          out_row_d    = '0;
          mid_slot_d   = 2'd0;
        end
      end

      StFetch: begin
        if (rd_ack) begin
          fetch_row_d  = fetch_row_q + RowOne;
          fetch_slot_d = slot_inc(fetch_slot_q);
          // Row 0 is the first of the two priming fetches; every later
          // fetch completes a window.
          if (fetch_row_q != '0) begin
            state_d = StCompute;
          end
        end
      end

      StCompute: begin
        if (out_ready) begin
          if (out_row_q == LastRow) begin
            state_d = StDone;
          end else begin
            out_row_d  = out_row_q + RowOne;
            mid_slot_d = slot_inc(mid_slot_q);
            // Once the last row is resident, the final window needs no fetch.
            state_d    = (out_row_q == PenultRow) ? StCompute : StFetch;
          end
        end
      end

      StDone: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Outputs decoded from registered state; only load_en sees rd_ack.
  always_comb begin
    rd_req    = (state_q == StFetch);
    rd_addr   = rd_req ? fetch_row_q : '0;
    load_sel  = rd_req ? fetch_slot_q : 2'd0;
    load_en   = rd_req & rd_ack;

    win_valid = (state_q == StCompute);
    win_top   = 2'd0;
    win_mid   = 2'd0;
    win_bot   = 2'd0;
    if (win_valid) begin
      win_mid = mid_slot_q;
      win_top = (out_row_q == '0) ? mid_slot_q : slot_dec(mid_slot_q);
      win_bot = (out_row_q == LastRow) ? mid_slot_q : slot_inc(mid_slot_q);
    end

    out_row   = out_row_q;
    busy      = (state_q != StIdle);
    done      = (state_q == StDone);
  end

endmodule

// File: tb/tb_sobel_row_scheduler.sv
// Bench for sobel_row_scheduler: one 256-row and one 3-row instance, checked
// against a frame-level scoreboard derived from the row/window rules.
module tb_sobel_row_scheduler;

  localparam int unsigned AW = 8;

  logic CLK = 1'b0;
  logic RST;
  logic [1:0] start_a, ack_a, ordy_a;
  logic [1:0] rd_req_a, load_en_a, win_valid_a, busy_a, done_a;
  logic [1:0][AW-1:0] rd_addr_a, out_row_a;
  logic [1:0][1:0] sel_a, top_a, mid_a, bot_a;

  int n_vec = 0;
  int n_err = 0;
  int mode = 0;
  int rows [2] = '{256, 3};

  // Scoreboard: fetches and transfers seen in the current frame.
  int nf [2];
  int nt [2];
  // Previous-cycle snapshot for cycle-to-cycle rules.
  int pv [2], p_busy [2], p_start [2], p_req [2], p_ack [2], p_addr [2], p_sel [2];
  int p_wv [2], p_ordy [2], p_row [2], p_top [2], p_mid [2], p_bot [2], p_done [2];
  // Stall bookkeeping: driver-side and observed.
  int drv_fs [2], drv_os [2], mon_fs [2], mon_os [2];

  always #5 CLK = ~CLK;

  sobel_row_scheduler #(.ROW(256), .AW(AW)) u_dut (
    .CLK      (CLK),
    .RST      (RST),
    .start    (start_a[0]),
    .rd_req   (rd_req_a[0]),
    .rd_addr  (rd_addr_a[0]),
    .rd_ack   (ack_a[0]),
    .load_en  (load_en_a[0]),
    .load_sel (sel_a[0]),
    .win_top  (top_a[0]),
    .win_mid  (mid_a[0]),
    .win_bot  (bot_a[0]),
    .win_valid(win_valid_a[0]),
    .out_ready(ordy_a[0]),
    .out_row  (out_row_a[0]),
    .busy     (busy_a[0]),
    .done     (done_a[0])
  );

  sobel_row_scheduler #(.ROW(3), .AW(AW)) u_dut3 (
    .CLK      (CLK),
    .RST      (RST),
    .start    (start_a[1]),
    .rd_req   (rd_req_a[1]),
    .rd_addr  (rd_addr_a[1]),
    .rd_ack   (ack_a[1]),
    .load_en  (load_en_a[1]),
    .load_sel (sel_a[1]),
    .win_top  (top_a[1]),
    .win_mid  (mid_a[1]),
    .win_bot  (bot_a[1]),
    .win_valid(win_valid_a[1]),
    .out_ready(ordy_a[1]),
    .out_row  (out_row_a[1]),
    .busy     (busy_a[1]),
    .done     (done_a[1])
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic check_cleared(input int i);
    check("clr_rd_req", rd_req_a[i], 0);
    check("clr_rd_addr", rd_addr_a[i], 0);
    check("clr_load_sel", sel_a[i], 0);
    check("clr_load_en", load_en_a[i], 0);
    check("clr_win_valid", win_valid_a[i], 0);
    check("clr_win_top", top_a[i], 0);
    check("clr_win_mid", mid_a[i], 0);
    check("clr_win_bot", bot_a[i], 0);
    check("clr_out_row", out_row_a[i], 0);
    check("clr_busy", busy_a[i], 0);
    check("clr_done", done_a[i], 0);
  endtask

  task automatic wait_done(input int i, input int budget);
    bit seen = 0;
    for (int k = 0; k < budget; k++) begin
      @(negedge CLK);
      if (done_a[i]) begin
        seen = 1;
        break;
      end
    end
    check("frame_done_seen", seen, 1);
  endtask

  // Per-cycle reference check for instance i, sampled mid-cycle.
  task automatic mon(input int i);
    int r, rw, exp_fetched;
    if (!RST) begin
      nf[i] = 0;
      nt[i] = 0;
      pv[i] = 0;
      return;
    end
    rw = rows[i];
    r  = nt[i];

    if (pv[i] != 0) begin
      if (p_done[i] != 0) begin
        check("busy_after_done", busy_a[i], 0);
        check("done_one_cycle", done_a[i], 0);
      end
      if (p_busy[i] == 0 && p_start[i] != 0) begin
        check("start_rd_req", rd_req_a[i], 1);
        check("start_rd_addr", rd_addr_a[i], 0);
      end
      if (p_req[i] != 0 && p_ack[i] == 0) begin
        check("fetch_hold_req", rd_req_a[i], 1);
        check("fetch_hold_addr", rd_addr_a[i], p_addr[i]);
        check("fetch_hold_sel", sel_a[i], p_sel[i]);
      end
      if (p_req[i] != 0 && p_ack[i] != 0) begin
        if (p_addr[i] == 0) begin
          check("prime_second_req", rd_req_a[i], 1);
          check("prime_second_addr", rd_addr_a[i], 1);
        end else begin
          check("fetch_to_compute", win_valid_a[i], 1);
          check("compute_row_after_fetch", out_row_a[i], p_addr[i] - 1);
        end
      end
      if (p_wv[i] != 0 && p_ordy[i] == 0) begin
        check("out_hold_valid", win_valid_a[i], 1);
        check("out_hold_row", out_row_a[i], p_row[i]);
        check("out_hold_top", top_a[i], p_top[i]);
        check("out_hold_mid", mid_a[i], p_mid[i]);
        check("out_hold_bot", bot_a[i], p_bot[i]);
        check("out_hold_no_fetch", rd_req_a[i], 0);
      end
      if (p_wv[i] != 0 && p_ordy[i] != 0) begin
        if (p_row[i] <= rw - 3) begin
          check("xfer_next_fetch_req", rd_req_a[i], 1);
          check("xfer_next_fetch_addr", rd_addr_a[i], p_row[i] + 2);
        end else if (p_row[i] == rw - 2) begin
          check("last_xfer_no_fetch", rd_req_a[i], 0);
          check("last_xfer_valid", win_valid_a[i], 1);
          check("last_xfer_row", out_row_a[i], p_row[i] + 1);
        end else begin
          check("final_xfer_done", done_a[i], 1);
        end
      end
    end

    check("load_en_decode", load_en_a[i], rd_req_a[i] & ack_a[i]);
    check("busy_decode", busy_a[i], rd_req_a[i] | win_valid_a[i] | done_a[i]);
    check("req_valid_exclusive", rd_req_a[i] & win_valid_a[i], 0);
    if (!win_valid_a[i]) begin
      check("idle_window_zero", {top_a[i], mid_a[i], bot_a[i]}, 0);
    end

    if (mode == 2 && i == 0 && rd_req_a[i] && rd_addr_a[i] == 2 && !ack_a[i]) begin
      mon_fs[i]++;
      check("stall_load_sel", sel_a[i], 2);
      check("stall_load_en", load_en_a[i], 0);
      check("stall_win_valid", win_valid_a[i], 0);
    end
    if (mode == 2 && i == 0 && win_valid_a[i] && out_row_a[i] == 10 && !ordy_a[i]) begin
      mon_os[i]++;
      check("ostall_top", top_a[i], 0);
      check("ostall_mid", mid_a[i], 1);
      check("ostall_bot", bot_a[i], 2);
    end

    if (load_en_a[i]) begin
      check("fetch_addr", rd_addr_a[i], nf[i]);
      check("fetch_sel", sel_a[i], nf[i] % 3);
      check("fetch_order", nt[i], (nf[i] < 2) ? 0 : nf[i] - 1);
      nf[i]++;
    end
    if (win_valid_a[i] && ordy_a[i]) begin
      exp_fetched = (r + 2 < rw) ? r + 2 : rw;
      check("xfer_row", out_row_a[i], r);
      check("xfer_top", top_a[i], ((r == 0) ? 0 : r - 1) % 3);
      check("xfer_mid", mid_a[i], r % 3);
      check("xfer_bot", bot_a[i], ((r == rw - 1) ? r : r + 1) % 3);
      check("xfer_fetched", nf[i], exp_fetched);
      nt[i]++;
    end
    if (done_a[i]) begin
      check("done_xfers", nt[i], rw);
      check("done_fetches", nf[i], rw);
      nf[i] = 0;
      nt[i] = 0;
    end

    pv[i]      = 1;
    p_busy[i]  = int'(busy_a[i]);
    p_start[i] = int'(start_a[i]);
    p_req[i]   = int'(rd_req_a[i]);
    p_ack[i]   = int'(ack_a[i]);
    p_addr[i]  = int'(rd_addr_a[i]);
    p_sel[i]   = int'(sel_a[i]);
    p_wv[i]    = int'(win_valid_a[i]);
    p_ordy[i]  = int'(ordy_a[i]);
    p_row[i]   = int'(out_row_a[i]);
    p_top[i]   = int'(top_a[i]);
    p_mid[i]   = int'(mid_a[i]);
    p_bot[i]   = int'(bot_a[i]);
    p_done[i]  = int'(done_a[i]);
  endtask

  always @(negedge CLK) begin
    mon(0);
    mon(1);
  end

  // Handshake driver: ack/ready tied high, random, or directed stalls.
  initial begin
    ack_a  = '1;
    ordy_a = '1;
    forever begin
      tick();
      for (int i = 0; i < 2; i++) begin
        case (mode)
          1: begin
            ack_a[i]  = ($urandom_range(0, 3) != 0);
            ordy_a[i] = ($urandom_range(0, 3) != 0);
          end
          2: begin
            ack_a[i]  = 1'b1;
            ordy_a[i] = 1'b1;
            if (rd_req_a[i] && rd_addr_a[i] == 2 && drv_fs[i] < 5) begin
              ack_a[i] = 1'b0;
              drv_fs[i]++;
            end
            if (win_valid_a[i] && out_row_a[i] == 10 && drv_os[i] < 4) begin
              ordy_a[i] = 1'b0;
              drv_os[i]++;
            end
          end
          default: begin
            ack_a[i]  = 1'b1;
            ordy_a[i] = 1'b1;
          end
        endcase
      end
    end
  end

  initial begin
    bit found;
    RST     = 1'b0;
    start_a = '1;
    mode    = 0;

    // Reset held with start asserted.
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    check_cleared(0);
    check_cleared(1);
    tick();
    RST     = 1'b1;
    start_a = '0;
    @(posedge CLK);
    @(negedge CLK);
    check("idle_busy", busy_a[0], 0);
    check("idle_rd_req", rd_req_a[0], 0);

    // Full frames with ack/ready tied high.
    tick();
    start_a = '1;
    tick();
    start_a = '0;
    wait_done(1, 100);
    wait_done(0, 2000);

    // Directed fetch and output stalls.
    tick();
    mode       = 2;
    start_a[0] = 1'b1;
    tick();
    start_a[0] = 1'b0;
    wait_done(0, 3000);
    check("fetch_stall_cycles", mon_fs[0], 5);
    check("out_stall_cycles", mon_os[0], 4);

    // Random handshakes, ignored mid-frame start, reset at row 100.
    tick();
    mode       = 1;
    start_a[0] = 1'b1;
    tick();
    start_a[0] = 1'b0;
    repeat (20) tick();
    start_a[0] = 1'b1;
    tick();
    start_a[0] = 1'b0;
    found = 0;
    for (int k = 0; k < 6000; k++) begin
      @(negedge CLK);
      if (win_valid_a[0] && out_row_a[0] == 100) begin
        found = 1;
        break;
      end
    end
    check("reach_row_100", found, 1);
    tick();
    RST = 1'b0;
    @(negedge CLK);
    tick();
    RST = 1'b1;
    @(negedge CLK);
    check_cleared(0);

    // Fresh frames after the abandoned one.
    tick();
    start_a = '1;
    tick();
    start_a = '0;
    wait_done(1, 500);
    wait_done(0, 6000);

    tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
